// File: rtl/l2_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// l2_arbiter_types
//   Shared types and helpers for the L1->L2 miss-port arbiter.
//   arb_state_t : arbiter FSM state (idle, or which L1 currently owns the L2 port)
//   arb_side_t  : identifies a requester, used for the round-robin history bit
//   line_align  : clears the line-offset bits of an address
// -----------------------------------------------------------------------------
package l2_arbiter_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } arb_side_t;

    // The L2 is always written a full line, so every byte lane is enabled.
    localparam logic [3:0] L2_BYTE_EN_ALL = 4'hF;

    function automatic logic [31:0] line_align(input logic [31:0] addr,
                                               input int unsigned offset_bits);
        logic [31:0] mask;
        mask = ~((32'd1 << offset_bits) - 32'd1);
        return addr & mask;
    endfunction

endpackage

// File: rtl/l2_arbiter.sv
// -----------------------------------------------------------------------------
// l2_arbiter
//   Shares the single CPU-side port of l2_cache between the I-cache and D-cache
//   miss ports. One full-line transaction is granted at a time; ties are broken
//   round-robin against the side that was served last. Responses from the L2 are
//   routed only to the side holding the grant.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_read / i_address       I-cache line read request (held until i_resp)
//   i_resp / i_rdata         I-cache response pulse and line data
//   d_read / d_write         D-cache line read / write-back request (held until d_resp)
//   d_address / d_wdata      D-cache line address and write-back data
//   d_resp / d_rdata         D-cache response pulse and line data
//   l2_read / l2_write       request strobes toward l2_cache
//   l2_byte_en               byte enables toward l2_cache (always all ones)
//   l2_address / l2_wdata    line-aligned address and write data toward l2_cache
//   l2_resp / l2_rdata       response and read data from l2_cache
// -----------------------------------------------------------------------------
module l2_arbiter
    import l2_arbiter_types::*;
#(
    parameter int s_offset = 5,
    parameter int s_line   = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [31:0]       i_address,
    output logic              i_resp,
    output logic [s_line-1:0] i_rdata,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_address,
    input  logic [s_line-1:0] d_wdata,
    output logic              d_resp,
    output logic [s_line-1:0] d_rdata,

    output logic              l2_read,
    output logic              l2_write,
    output logic [3:0]        l2_byte_en,
    output logic [31:0]       l2_address,
    output logic [s_line-1:0] l2_wdata,
    input  logic              l2_resp,
    input  logic [s_line-1:0] l2_rdata
);

    arb_state_t state;
    arb_state_t state_next;
    arb_side_t  last_grant;
    arb_side_t  last_grant_next;

    logic i_pend;
    logic d_pend;

    assign i_pend = i_read;
    assign d_pend = d_read | d_write;

    assign l2_byte_en = L2_BYTE_EN_ALL;

    // Reset leaves last_grant at SIDE_I so the D-cache wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= SIDE_I;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    // A grant is only released by l2_resp; the requester's inputs cannot cancel
    // it, so a stray drop still waits out the L2 transaction.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        case (state)
            IDLE: begin
                if (i_pend && d_pend) begin
                    state_next = (last_grant == SIDE_I) ? GRANT_D : GRANT_I;
                end else if (i_pend) begin
                    state_next = GRANT_I;
                end else if (d_pend) begin
                    state_next = GRANT_D;
                end
            end
            GRANT_I: begin
                if (l2_resp) begin
                    state_next      = IDLE;
                    last_grant_next = SIDE_I;
                end
            end
            GRANT_D: begin
                if (l2_resp) begin
                    state_next      = IDLE;
                    last_grant_next = SIDE_D;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are gated by rst so that a reset arriving mid-grant silences the
    // L2 strobes in the reset cycle itself, before the state register clears.
    always_comb begin
        i_resp     = 1'b0;
        i_rdata    = '0;
        d_resp     = 1'b0;
        d_rdata    = '0;
        l2_read    = 1'b0;
        l2_write   = 1'b0;
        l2_address = '0;
        l2_wdata   = '0;
        if (!rst) begin
            case (state)
                GRANT_I: begin
                    l2_read    = i_read;
                    l2_address = line_align(i_address, s_offset);
                    if (l2_resp) begin
                        i_resp  = 1'b1;
                        i_rdata = l2_rdata;
                    end
                end
                GRANT_D: begin
                    // Read and write together is illegal; the write wins.
                    l2_read    = d_read & ~d_write;
                    l2_write   = d_write;
                    l2_address = line_align(d_address, s_offset);
                    l2_wdata   = d_wdata;
                    if (l2_resp) begin
                        d_resp  = 1'b1;
                        d_rdata = l2_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_arbiter.sv
module tb_l2_arbiter;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_read = 1'b0;
    logic [31:0]   i_address = '0;
    logic          i_resp;
    logic [LW-1:0] i_rdata;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [31:0]   d_address = '0;
    logic [LW-1:0] d_wdata = '0;
    logic          d_resp;
    logic [LW-1:0] d_rdata;
    logic          l2_read;
    logic          l2_write;
    logic [3:0]    l2_byte_en;
    logic [31:0]   l2_address;
    logic [LW-1:0] l2_wdata;
    logic          l2_resp = 1'b0;
    logic [LW-1:0] l2_rdata = '0;

    l2_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .l2_read(l2_read), .l2_write(l2_write), .l2_byte_en(l2_byte_en),
        .l2_address(l2_address), .l2_wdata(l2_wdata),
        .l2_resp(l2_resp), .l2_rdata(l2_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Behavioural model: who owns the L2 port (-1 nobody, 0 I-cache, 1 D-cache)
    // and which side was served most recently.
    int owner = -1;
    int last_side = 0;

    always @(posedge clk) begin
        if (rst) begin
            owner     <= -1;
            last_side <= 0;
        end else if (owner < 0) begin
            if (i_read && (d_read || d_write))
                owner <= 1 - last_side;
            else if (i_read)
                owner <= 0;
            else if (d_read || d_write)
                owner <= 1;
        end else if (l2_resp) begin
            last_side <= owner;
            owner     <= -1;
        end
    end

    always @(posedge clk) begin
        if (!rst)
            assert (!(d_read && d_write)) else $error("illegal d_read+d_write");
    end

    // Compare every cycle against what the model says the port must show.
    always @(negedge clk) begin : cmp
        logic          e_ir, e_dr, e_rd, e_wr;
        logic [LW-1:0] e_ird, e_drd, e_wd;
        logic [31:0]   e_addr;
        e_ir = 0; e_dr = 0; e_rd = 0; e_wr = 0;
        e_ird = '0; e_drd = '0; e_wd = '0; e_addr = '0;
        if (!rst && owner == 0) begin
            e_rd   = i_read;
            e_addr = {i_address[31:5], 5'b0};
            if (l2_resp) begin e_ir = 1; e_ird = l2_rdata; end
        end else if (!rst && owner == 1) begin
            e_rd   = d_read && !d_write;
            e_wr   = d_write;
            e_addr = {d_address[31:5], 5'b0};
            e_wd   = d_wdata;
            if (l2_resp) begin e_dr = 1; e_drd = l2_rdata; end
        end
        check("m_i_resp", i_resp, e_ir);
        check("m_i_rdata", i_rdata, e_ird);
        check("m_d_resp", d_resp, e_dr);
        check("m_d_rdata", d_rdata, e_drd);
        check("m_l2_read", l2_read, e_rd);
        check("m_l2_write", l2_write, e_wr);
        check("m_l2_address", l2_address, e_addr);
        check("m_l2_wdata", l2_wdata, e_wd);
        check("m_l2_byte_en", l2_byte_en, 4'hF);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int order[$];
        int want[6] = '{1, 0, 1, 0, 1, 0};
        int wait_cnt;
        logic s_ir, s_dr, s_req;

        // Reset with requests present: everything quiet, byte enables still on.
        i_read = 1; d_write = 1; d_address = 32'h0000_0100;
        tick(); tick();
        check("rst_l2_read", l2_read, 0);
        check("rst_l2_write", l2_write, 0);
        check("rst_byte_en", l2_byte_en, 4'hF);
        check("rst_l2_address", l2_address, 0);
        i_read = 0; d_write = 0;
        tick();
        rst = 0;
        tick();

        // 1: I-cache only
        i_read = 1; i_address = 32'h0000_1234;
        tick();
        check("t1_l2_read", l2_read, 1);
        check("t1_l2_address", l2_address, 32'h0000_1220);
        l2_rdata = {32{8'hA5}}; l2_resp = 1; #1;
        check("t1_i_resp", i_resp, 1);
        check("t1_i_rdata", i_rdata, {32{8'hA5}});
        check("t1_d_resp", d_resp, 0);
        tick();
        l2_resp = 0;
        check("t1_idle_after", l2_read, 0);
        i_read = 0;
        tick();

        // 2 + 4: tie goes to D first, I isolated while D is served
        i_read = 1; i_address = 32'h0000_0444;
        d_write = 1; d_address = 32'h8000_0040; d_wdata = 256'h1;
        tick();
        check("t2_l2_write", l2_write, 1);
        check("t2_l2_read", l2_read, 0);
        check("t2_l2_wdata", l2_wdata, 256'h1);
        check("t2_l2_address", l2_address, 32'h8000_0040);
        l2_rdata = {32{8'h5A}}; l2_resp = 1; #1;
        check("t4_d_resp", d_resp, 1);
        check("t4_i_resp", i_resp, 0);
        check("t4_i_rdata", i_rdata, 0);
        tick();
        l2_resp = 0; d_write = 0;
        tick();
        check("t2_i_next", l2_read, 1);
        check("t2_i_address", l2_address, 32'h0000_0440);
        l2_resp = 1; #1;
        check("t2_i_resp", i_resp, 1);
        tick();
        l2_resp = 0; i_read = 0;
        tick();

        // 3: both requesting continuously -> strict alternation
        i_read = 1; i_address = 32'h0000_1000;
        d_read = 1; d_address = 32'h0000_2000;
        for (int cyc = 0; cyc < 200 && order.size() < 6; cyc++) begin
            tick();
            l2_resp = 0;
            if (l2_read || l2_write) begin
                l2_rdata = rand_line(); l2_resp = 1; #1;
                if (i_resp) order.push_back(0);
                else if (d_resp) order.push_back(1);
                else order.push_back(9);
            end
        end
        check("t3_count", order.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < order.size()) check($sformatf("t3_grant%0d", k), order[k], want[k]);
        end
        tick();
        l2_resp = 0; i_read = 0; d_read = 0;
        tick();

        // 5: reset mid-grant
        i_read = 1; i_address = 32'h0000_3000;
        tick();
        check("t5_granted", l2_read, 1);
        rst = 1; #1;
        check("t5_rst_l2_read", l2_read, 0);
        tick();
        rst = 0; i_read = 0; #1;
        check("t5_after_rst", l2_read, 0);
        tick();
        i_read = 1; d_read = 1; d_address = 32'h0000_4008;
        tick();
        check("t5_tie_d", l2_address, 32'h0000_4000);
        l2_resp = 1; #1;
        check("t5_d_resp", d_resp, 1);
        tick();
        l2_resp = 0; d_read = 0;
        tick(); tick();
        l2_resp = 1; #1;
        check("t5_i_resp", i_resp, 1);
        tick();
        l2_resp = 0; i_read = 0;
        tick();

        // 6: stray l2_resp while idle
        l2_resp = 1; l2_rdata = rand_line(); #1;
        check("t6_i_resp", i_resp, 0);
        check("t6_d_resp", d_resp, 0);
        tick();
        l2_resp = 0; i_read = 1; i_address = 32'h0000_5010;
        tick();
        check("t6_then_grant", l2_read, 1);
        l2_resp = 1;
        tick();
        l2_resp = 0; i_read = 0;
        tick();

        // Random traffic, model-checked every cycle
        wait_cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            s_ir = i_resp; s_dr = d_resp; s_req = l2_read | l2_write;
            @(posedge clk);
            #1;
            if (rst) begin
                rst = 0;
            end else if ($urandom_range(0, 499) == 0) begin
                rst = 1; i_read = 0; d_read = 0; d_write = 0; l2_resp = 0;
            end else begin
                if (i_read) begin
                    if (s_ir) i_read = 0;
                end else if ($urandom_range(0, 3) == 0) begin
                    i_read = 1; i_address = $urandom;
                end
                if (d_read || d_write) begin
                    if (s_dr) begin d_read = 0; d_write = 0; end
                end else if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) == 1) d_write = 1; else d_read = 1;
                    d_address = $urandom; d_wdata = rand_line();
                end
                if (l2_resp) begin
                    l2_resp = 0;
                end else if (s_req) begin
                    if (wait_cnt == 0) begin
                        l2_resp = 1; l2_rdata = rand_line();
                        wait_cnt = $urandom_range(0, 4);
                    end else begin
                        wait_cnt--;
                    end
                end else if ($urandom_range(0, 29) == 0) begin
                    l2_resp = 1; l2_rdata = rand_line();
                end
            end
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
